// File: rtl/fetch_decode_latch.sv
// fetch_decode_latch: fetch/decode pipeline register with two-word instruction assembly.
//   clk, rstn (sync, active-high reset)
//   in : i_instruction, i_pc, i_pc_1, i_valid, i_stall, i_flush
//   out: o_instruction, o_immediate, o_pc, o_pc_1, o_valid, o_has_imm (registered)
//        o_fetch_hold (combinational), o_bubble_cnt (saturating count of o_valid=0 edges)
module fetch_decode_latch #(
  parameter int INSTR_WIDTH = 16,
  parameter int PC_WIDTH    = 12,
  parameter int IMM_BIT     = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [INSTR_WIDTH-1:0] i_instruction,
  input  logic [PC_WIDTH-1:0]    i_pc,
  input  logic [PC_WIDTH-1:0]    i_pc_1,
  input  logic                   i_valid,
  input  logic                   i_stall,
  input  logic                   i_flush,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [INSTR_WIDTH-1:0] o_immediate,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic [PC_WIDTH-1:0]    o_pc_1,
  output logic                   o_valid,
  output logic                   o_has_imm,
  output logic                   o_fetch_hold,
  output logic [CNT_WIDTH-1:0]   o_bubble_cnt
);
  typedef enum logic {S_OP, S_IMM} state_t;
  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] pend_op_q, pend_op_d, instr_q, instr_d, imm_q, imm_d;
  logic [PC_WIDTH-1:0]    pend_pc_q, pend_pc_d, pc_q, pc_d, pc1_q, pc1_d;
  logic                   valid_q, valid_d, has_imm_q, has_imm_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   advance, is_two_word;
  assign advance     = ~i_flush & ~i_stall & i_valid;
  assign is_two_word = i_instruction[IMM_BIT];
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q   <= S_OP;
      pend_op_q <= '0;
      pend_pc_q <= '0;
      instr_q   <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      pc1_q     <= '0;
      valid_q   <= 1'b0;
      has_imm_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_op_q <= pend_op_d;
      pend_pc_q <= pend_pc_d;
      instr_q   <= instr_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      pc1_q     <= pc1_d;
      valid_q   <= valid_d;
      has_imm_q <= has_imm_d;
      cnt_q     <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (i_flush) state_d = S_OP;
    else if (advance) state_d = (state_q == S_OP && is_two_word) ? S_IMM : S_OP;
  end
  always_comb begin
    pend_op_d = pend_op_q;
    pend_pc_d = pend_pc_q;
    instr_d   = instr_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    pc1_d     = pc1_q;
    valid_d   = valid_q;
    has_imm_d = has_imm_q;
    if (i_flush) begin
      pend_op_d = '0;
      pend_pc_d = '0;
      instr_d   = '0;
      imm_d     = '0;
      valid_d   = 1'b0;
      has_imm_d = 1'b0;
    end else if (!i_stall) begin
      imm_d     = '0;
      valid_d   = 1'b0;
      has_imm_d = 1'b0;
      if (i_valid && state_q == S_IMM) begin
        instr_d   = pend_op_q;
        imm_d     = i_instruction;
        pc_d      = pend_pc_q;
        pc1_d     = i_pc_1;
        valid_d   = 1'b1;
        has_imm_d = 1'b1;
      end else if (i_valid && is_two_word) begin
        pend_op_d = i_instruction;
        pend_pc_d = i_pc;
      end else if (i_valid) begin
        instr_d = i_instruction;
        pc_d    = i_pc;
        pc1_d   = i_pc_1;
        valid_d = 1'b1;
      end
    end
    cnt_d = (!valid_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  assign o_fetch_hold  = i_stall & ~i_flush;
  assign o_instruction = instr_q;
  assign o_immediate   = imm_q;
  assign o_pc          = pc_q;
  assign o_pc_1        = pc1_q;
  assign o_valid       = valid_q;
  assign o_has_imm     = has_imm_q;
  assign o_bubble_cnt  = cnt_q;
endmodule

// File: tb/tb_fetch_decode_latch.sv
// tb_fetch_decode_latch: directed plus random stimulus against a transaction-level reference model.
module tb_fetch_decode_latch;
  localparam int IW = 16, PW = 12, CW = 4;
  logic clk = 1'b0, rstn = 1'b1;
  logic [IW-1:0] i_instruction = '0;
  logic [PW-1:0] i_pc = '0, i_pc_1 = '0;
  logic i_valid = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
  logic [IW-1:0] o_instruction, o_immediate;
  logic [PW-1:0] o_pc, o_pc_1;
  logic o_valid, o_has_imm, o_fetch_hold;
  logic [CW-1:0] o_bubble_cnt;
  int n_assert = 0, n_fail = 0;
  typedef struct { logic [IW-1:0] op; logic [PW-1:0] pc; } pend_t;
  pend_t pend_q[$];
  logic [IW-1:0] m_ins = '0, m_imm = '0;
  logic [PW-1:0] m_pc = '0, m_pc1 = '0;
  logic m_valid = 1'b0, m_has_imm = 1'b0;
  int m_cnt = 0;
  fetch_decode_latch #(.INSTR_WIDTH(IW), .PC_WIDTH(PW), .IMM_BIT(0), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .i_instruction(i_instruction), .i_pc(i_pc), .i_pc_1(i_pc_1),
    .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush), .o_instruction(o_instruction),
    .o_immediate(o_immediate), .o_pc(o_pc), .o_pc_1(o_pc_1), .o_valid(o_valid),
    .o_has_imm(o_has_imm), .o_fetch_hold(o_fetch_hold), .o_bubble_cnt(o_bubble_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_edge();
    pend_t p;
    if (rstn) begin
      pend_q.delete();
      {m_ins, m_imm, m_pc, m_pc1, m_valid, m_has_imm} = '0;
      m_cnt = 0;
      return;
    end
    if (i_flush) begin
      pend_q.delete();
      {m_ins, m_imm, m_valid, m_has_imm} = '0;
    end else if (!i_stall) begin
      m_valid = 1'b0; m_has_imm = 1'b0; m_imm = '0;
      if (i_valid && pend_q.size() != 0) begin
        p = pend_q.pop_front();
        m_ins = p.op; m_imm = i_instruction; m_pc = p.pc; m_pc1 = i_pc_1;
        m_valid = 1'b1; m_has_imm = 1'b1;
      end else if (i_valid && i_instruction[0]) begin
        pend_q.push_back('{op: i_instruction, pc: i_pc});
      end else if (i_valid) begin
        m_ins = i_instruction; m_pc = i_pc; m_pc1 = i_pc_1; m_valid = 1'b1;
      end
    end
    if (!m_valid) m_cnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
  endtask
  task automatic step(input logic [IW-1:0] w, input logic [PW-1:0] pc, input logic v,
                      input logic st, input logic fl, input logic rs);
    @(negedge clk);
    i_instruction = w; i_pc = pc; i_pc_1 = pc + 1'b1; i_valid = v;
    i_stall = st; i_flush = fl; rstn = rs;
    #1 chk("fetch_hold", 32'(o_fetch_hold), 32'(st & ~fl));
    @(posedge clk);
    model_edge();
    #1;
    chk("instruction", 32'(o_instruction), 32'(m_ins));
    chk("immediate", 32'(o_immediate), 32'(m_imm));
    chk("pc", 32'(o_pc), 32'(m_pc));
    chk("pc_1", 32'(o_pc_1), 32'(m_pc1));
    chk("valid", 32'(o_valid), 32'(m_valid));
    chk("has_imm", 32'(o_has_imm), 32'(m_has_imm));
    chk("bubble_cnt", 32'(o_bubble_cnt), 32'(m_cnt));
  endtask
  initial begin
    step('0, 0, 0, 0, 0, 1);
    chk("reset_valid_const", 32'(o_valid), 32'd0);
    step(16'h1230, 0, 1, 0, 0, 0);
    chk("t1_ins0", 32'(o_instruction), 32'h1230);
    step(16'h4560, 1, 1, 0, 0, 0);
    chk("t1_ins1", 32'(o_instruction), 32'h4560);
    chk("t1_pc1", 32'(o_pc_1), 32'd2);
    for (int i = 0; i < 3; i++) step(16'h7770, 2, 1, 1, 0, 0);
    chk("t3_frozen", 32'(o_instruction), 32'h4560);
    chk("t3_cnt", 32'(o_bubble_cnt), 32'd0);
    step(16'h8001, 4, 1, 0, 0, 0);
    chk("t2_bubble", 32'(o_bubble_cnt), 32'd1);
    step(16'hBEEF, 5, 1, 0, 0, 0);
    chk("t2_imm", 32'(o_immediate), 32'hBEEF);
    chk("t2_pc1", 32'(o_pc_1), 32'd6);
    step(16'h8001, 8, 1, 0, 0, 0);
    step(16'h1111, 9, 1, 1, 1, 0);
    step(16'h2220, 20, 1, 0, 0, 0);
    chk("t4_opcode", 32'(o_instruction), 32'h2220);
    step(16'h8001, 30, 1, 0, 0, 0);
    step(16'h3333, 31, 1, 0, 0, 1);
    chk("t5_reset_cnt", 32'(o_bubble_cnt), 32'd0);
    step(16'h0010, 40, 1, 0, 0, 0);
    chk("t5_single", 32'(o_has_imm), 32'd0);
    for (int i = 0; i < (1 << CW) + 5; i++) step($urandom, $urandom, 0, 0, 0, 0);
    chk("t6_saturated", 32'(o_bubble_cnt), 32'd15);
    step('0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++)
      step($urandom, $urandom, $urandom_range(0, 4) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
